mdu: RTL and testbench

- Multi-cycle multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core.
- Sits beside the execute-stage ALU and accepts one operation per start pulse from E.
- Drives busy to the hazard unit, which stalls MFHI/MFLO and further MDU ops in D while busy is high.
- Parametrised in operand width and multiplier latency; adds signed and unsigned divide and in-flight cancel on flush, which the single-cycle ALU path lacks.

---
 rtl/mips_pkg.sv | 15 +
 rtl/mdu_div.sv | 64 ++++++
 rtl/mdu.sv | 127 ++++++++++++
 tb/tb_mdu.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared MDU types and constants for the MIPS core
package mips_pkg;
  localparam int MDU_WIDTH = 32;
  localparam int MDU_DIV_CYCLES = MDU_WIDTH + 1;
  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } mdu_op_t;
  typedef enum logic [1:0] {IDLE, MUL, DIV} mdu_state_t;
endpackage

// File: rtl/mdu_div.sv
// mdu_div: iterative restoring divider on unsigned magnitudes, one quotient bit per cycle
module mdu_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cancel,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             valid
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic run_q, run_d, valid_q, valid_d;
  logic [WIDTH:0] trial;
  always_comb begin
    trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    run_d = run_q;
    valid_d = 1'b0;
    if (cancel) run_d = 1'b0;
    else if (start) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
      cnt_d = CW'(WIDTH - 1);
      run_d = 1'b1;
    end else if (run_q) begin
      // a borrow out of the trial subtraction means restore the shifted remainder
      rem_d = trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
      cnt_d = cnt_q - 1'b1;
      run_d = cnt_q != '0;
      valid_d = cnt_q == '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= 1'b0;
      valid_q <= 1'b0;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else begin
      run_q <= run_d;
      valid_q <= valid_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end
  assign quotient = quo_q;
  assign remainder = rem_q;
  assign valid = valid_q;
endmodule

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit owning the architectural HI/LO registers
module mdu
  import mips_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int MUL_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  mdu_op_t          op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  mdu_state_t state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, a_q, a_d, b_q, b_d;
  logic [2:0] cnt_q, cnt_d;
  logic sgn_q, sgn_d, qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d, done_q, done_d;
  logic accept, is_div, div_sgn, div_valid;
  logic [WIDTH-1:0] mag_a, mag_b, quo, rem, div_hi, div_lo;
  logic [2*WIDTH-1:0] prod, mul_res;
  assign accept = start && !cancel && state_q == IDLE;
  assign is_div = op_i == OP_DIV || op_i == OP_DIVU;
  assign div_sgn = op_i == OP_DIV;
  assign mag_a = (div_sgn && a_i[WIDTH-1]) ? -a_i : a_i;
  assign mag_b = (div_sgn && b_i[WIDTH-1]) ? -b_i : b_i;
  mdu_div #(.WIDTH(WIDTH)) u_div (
    .clk(clk),
    .rst(rst),
    .start(accept && is_div),
    .cancel(cancel),
    .dividend(mag_a),
    .divisor(mag_b),
    .quotient(quo),
    .remainder(rem),
    .valid(div_valid)
  );
  // extending both operands to 2*WIDTH makes one multiplier serve MULT and MULTU
  assign prod = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q} * {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};
  if (MUL_STAGES == 1) begin : g_nopipe
    assign mul_res = prod;
  end else begin : g_pipe
    logic [2*WIDTH-1:0] pipe_q [MUL_STAGES-1];
    always_ff @(posedge clk) begin
      pipe_q[0] <= prod;
      for (int i = 1; i < MUL_STAGES - 1; i++) pipe_q[i] <= pipe_q[i-1];
    end
    assign mul_res = pipe_q[MUL_STAGES-2];
  end
  assign div_lo = dz_q ? '1 : qneg_q ? -quo : quo;
  assign div_hi = dz_q ? a_q : rneg_q ? -rem : rem;
  always_comb begin
    state_d = state_q;
    hi_d = hi_q;
    lo_d = lo_q;
    a_d = a_q;
    b_d = b_q;
    cnt_d = cnt_q;
    sgn_d = sgn_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    dz_d = dz_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        if (op_i == OP_MTHI) hi_d = a_i;
        if (op_i == OP_MTLO) lo_d = a_i;
        if (op_i == OP_MULT || op_i == OP_MULTU || is_div) begin
          state_d = is_div ? DIV : MUL;
          a_d = a_i;
          b_d = b_i;
          cnt_d = 3'(MUL_STAGES - 1);
          sgn_d = op_i == OP_MULT || div_sgn;
          qneg_d = div_sgn && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
          rneg_d = div_sgn && a_i[WIDTH-1];
          dz_d = b_i == '0;
        end
      end
      MUL: if (cancel) state_d = IDLE;
        else if (cnt_q == '0) begin
          {hi_d, lo_d} = mul_res;
          done_d = 1'b1;
          state_d = IDLE;
        end else cnt_d = cnt_q - 1'b1;
      DIV: if (cancel) state_d = IDLE;
        else if (div_valid) begin
          hi_d = div_hi;
          lo_d = div_lo;
          done_d = 1'b1;
          state_d = IDLE;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hi_q <= '0;
      lo_q <= '0;
      done_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      done_q <= done_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
    sgn_q <= sgn_d;
    qneg_q <= qneg_d;
    rneg_q <= rneg_d;
    dz_q <= dz_d;
  end
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed vectors with a done-driven scoreboard for the MDU
module tb_mdu;
  import mips_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic cancel = 1'b0;
  mdu_op_t op_i = OP_NOP;
  logic [31:0] a_i = '0, b_i = '0;
  logic busy, done;
  logic [31:0] hi, lo;
  int tests = 0;
  int fails = 0;
  logic [63:0] exp_q [$];

  mdu #(.WIDTH(32), .MUL_STAGES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) check("unexpected_done", {hi, lo}, 64'hx);
      else check("sb_hi_lo", {hi, lo}, exp_q.pop_front());
    end
  end

  task automatic issue(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op_i = op;
    a_i = a;
    b_i = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_i = OP_NOP;
  endtask

  task automatic run_op(input string name, input mdu_op_t op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int lat);
    int n = 0;
    exp_q.push_back({eh, el});
    issue(op, a, b);
    @(negedge clk);
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    check({name, "_latency"}, 64'(n), 64'(lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_hi", 64'(hi), 64'h0);
    check("rst_lo", 64'(lo), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_done", 64'(done), 64'h0);

    run_op("mult", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 2);
    run_op("multu", OP_MULTU, 32'hFFFF_FFFD, 32'd5, 32'h0000_0004, 32'hFFFF_FFF1, 2);
    run_op("divu", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33);
    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    run_op("div_negb", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 33);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33);
    run_op("divu_zero", OP_DIVU, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF, 33);
    run_op("div_zero", OP_DIV, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 33);

    issue(OP_MTHI, 32'hAAAA_0000, 32'h0);
    check("mthi_hi", 64'(hi), 64'hAAAA_0000);
    check("mthi_busy", 64'(busy), 64'h0);
    check("mthi_done", 64'(done), 64'h0);
    issue(OP_MTLO, 32'h5555, 32'h0);
    check("mtlo_lo", 64'(lo), 64'h5555);
    check("mtlo_hi", 64'(hi), 64'hAAAA_0000);

    issue(OP_DIVU, 32'd9, 32'd3);
    repeat (8) @(posedge clk);
    #1;
    check("cancel_busy_before", 64'(busy), 64'h1);
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    check("cancel_busy", 64'(busy), 64'h0);
    repeat (40) @(posedge clk);
    #1;
    check("cancel_hi_lo", {hi, lo}, {32'hAAAA_0000, 32'h5555});

    exp_q.push_back({32'd2, 32'd8});
    issue(OP_DIVU, 32'd50, 32'd6);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    op_i = OP_MULT;
    a_i = 32'd3;
    b_i = 32'd3;
    @(posedge clk);
    #1;
    op_i = OP_MTLO;
    a_i = 32'hDEAD;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_i = OP_NOP;
    a_i = 32'd1;
    b_i = 32'd1;
    n = 5;
    @(negedge clk);
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("busy_ignore_latency", 64'(n), 64'd33);
    check("busy_ignore_hi_lo", {hi, lo}, {32'd2, 32'd8});

    cancel = 1'b1;
    issue(OP_MULT, 32'd2, 32'd2);
    cancel = 1'b0;
    check("cancel_start_busy", 64'(busy), 64'h0);
    repeat (4) @(posedge clk);
    #1;
    check("cancel_start_hi_lo", {hi, lo}, {32'd2, 32'd8});

    issue(OP_DIV, 32'd100, 32'd3);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_hi", 64'(hi), 64'h0);
    check("midrst_lo", 64'(lo), 64'h0);
    check("midrst_busy", 64'(busy), 64'h0);
    check("midrst_done", 64'(done), 64'h0);
    run_op("mult_after_rst", OP_MULT, 32'd7, 32'd6, 32'd0, 32'd42, 2);
    repeat (40) @(posedge clk);
    #1;
    check("sb_drain", 64'(exp_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
